req_driver: RTL and testbench
=============================

REQ_DRIVER -- requirements
Module: req_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 8, symbol buffer entries (power of 2, 2..16).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port load  input  1  write sym_in into buffer when load_ready=1.
REQ-005 SHALL have port sym_in  input  2  symbol {R1,R0} to queue.
REQ-006 SHALL have port load_ready  output  1  buffer not full and state IDLE.
REQ-007 SHALL have port start  input  1  begin emitting queued symbols (sampled in IDLE only).
REQ-008 SHALL have ports R1, R0  output  1 each  request symbol driven to pattern matcher.
REQ-009 SHALL have ports G0, G1  input  1 each  grant response from pattern matcher.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when sequence completes.
REQ-012 SHALL have port g0_count, g1_count  output  8 each  grant cycles counted during the sequence.
REQ-013 SHALL have port error  output  1  sticky grant-mismatch flag (see Configuration).

Function
REQ-014 SHALL queue symbols in a DEPTH-entry FIFO; load with load_ready=0 is ignored, no overwrite.
REQ-015 SHALL implement states IDLE, SEND, GAP, DRAIN.
REQ-016 IDLE: drive {R1,R0}=00; start=1 with FIFO non-empty -> SEND, clear counters and error; start with empty FIFO ignored.
REQ-017 SEND: each cycle pop one symbol and drive it on {R1,R0} that same cycle.
REQ-018 SEND: after driving 11 -> GAP (matcher ignores the following input); otherwise stay in SEND while FIFO non-empty, else -> DRAIN.
REQ-019 GAP: drive 00, pop nothing, last one cycle; then -> SEND if FIFO non-empty, else DRAIN.
REQ-020 DRAIN: drive 00 for exactly one cycle to capture the final response; then -> IDLE with done=1 for one cycle.
REQ-021 SHALL increment g0_count/g1_count on every cycle in SEND, GAP or DRAIN where G0/G1 is 1; saturate at 255.
REQ-022 Response timing: G for a symbol driven in cycle N is sampled in cycle N+1 (matcher state is registered).
REQ-023 load, start during non-IDLE states SHALL be ignored.

Reset
REQ-024 reset=1 SHALL force IDLE, empty FIFO, R1=R0=0, busy=0, done=0, counters=0, error=0 at next edge, including mid-sequence.
REQ-025 Reset SHALL take priority over load and start in the same cycle.

Configuration
REQ-026 Macro REQ_DRIVER_CHECK_EN SHALL gate the response checker.
REQ-027 Defined: predict expected {G1,G0} from previous-cycle driven symbol (00->00, 01->01, 10->10, 11->01, GAP cycle->10); any mismatch in the cycle after SEND/GAP SHALL set error until next start or reset.
REQ-028 Undefined: error SHALL be constant 0; no checker logic.

Verification
REQ-029 Load 01,10,00; start -> R=01,10,00 on three consecutive cycles, DRAIN, done pulse; g0_count=1, g1_count=1, error=0.
REQ-030 Load 11,01; start -> R=11, 00(GAP), 01, 00(DRAIN); g0_count=2, g1_count=1.
REQ-031 Load DEPTH symbols -> load_ready=0; extra load dropped; all DEPTH symbols emitted in order.
REQ-032 Start with empty FIFO -> stays IDLE, busy=0, no done.
REQ-033 Assert reset during SEND -> next cycle IDLE, R=00, counters 0, FIFO empty.
REQ-034 With REQ_DRIVER_CHECK_EN, force G1=1 after symbol 01 -> error=1, held until next start.

Source files
------------

// File: rtl/req_driver.sv
`default_nettype none
// ============================================================================
// Module   : req_driver
// Purpose  : Queues 2-bit request symbols {R1,R0} in a small FIFO and plays
//            them out to a registered pattern matcher. After a 11 symbol the
//            matcher ignores one input, so a GAP cycle is inserted. A final
//            DRAIN cycle lets the last response arrive. Grant cycles are
//            counted with saturation.
// Options  : REQ_DRIVER_CHECK_EN - when defined, enables a response checker
//            that predicts {G1,G0} one cycle after each SEND/GAP cycle and
//            raises a sticky error on mismatch. When undefined, error is 0.
// Revision : 1.0 - initial release
// ============================================================================
module req_driver #(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [1:0] sym_in,
  output logic       load_ready,
  input  logic       start,
  output logic       R1,
  output logic       R0,
  input  logic       G0,
  input  logic       G1,
  output logic       busy,
  output logic       done,
  output logic [7:0] g0_count,
  output logic [7:0] g1_count,
  output logic       error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    head;
  logic [1:0]    drive_sym;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          seq_start;

  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  assign load_ready = (state == IDLE) && (count != FULL_COUNT);
  assign push       = load && load_ready;
  // Every SEND cycle consumes exactly one symbol; the FIFO is never empty in SEND.
  assign pop        = (state == SEND);
  assign seq_start  = (state == IDLE) && start && !fifo_empty;
  assign busy       = (state != IDLE);

  // The symbol is driven in the same cycle it is popped; all other states idle the bus.
  assign drive_sym  = (state == SEND) ? head : 2'b00;
  assign R1         = drive_sym[1];
  assign R0         = drive_sym[0];

  // Symbol storage; contents need no reset because occupancy is tracked by count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= sym_in;
    end
  end

  // FIFO pointers and occupancy; push only in IDLE and pop only in SEND, so never both.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end else if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
    end
  end

  // Next-state selection for the playback sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (seq_start) state_nxt = SEND;
      end
      SEND: begin
        // count still includes the symbol being popped this cycle
        if (head == 2'b11)          state_nxt = GAP;
        else if (count > ONE_COUNT) state_nxt = SEND;
        else                        state_nxt = DRAIN;
      end
      GAP: begin
        state_nxt = fifo_empty ? DRAIN : SEND;
      end
      DRAIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register plus the one-cycle completion pulse on leaving DRAIN.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == DRAIN);
    end
  end

  // Saturating grant counters, cleared when a new sequence starts.
  always_ff @(posedge clock) begin
    if (reset) begin
      g0_count <= 8'd0;
      g1_count <= 8'd0;
    end else if (seq_start) begin
      g0_count <= 8'd0;
      g1_count <= 8'd0;
    end else if (state != IDLE) begin
      if (G0 && (g0_count != 8'hFF)) g0_count <= g0_count + 8'd1;
      if (G1 && (g1_count != 8'hFF)) g1_count <= g1_count + 8'd1;
    end
  end

`ifdef REQ_DRIVER_CHECK_EN
  logic       chk_valid;
  logic [1:0] chk_exp;
  logic       err_r;

  // Predict next-cycle response from what is driven now; flag any mismatch stickily.
  always_ff @(posedge clock) begin
    if (reset) begin
      chk_valid <= 1'b0;
      chk_exp   <= 2'b00;
      err_r     <= 1'b0;
    end else begin
      chk_valid <= (state == SEND) || (state == GAP);
      if (state == GAP)             chk_exp <= 2'b10;
      else if (drive_sym == 2'b11)  chk_exp <= 2'b01;
      else                          chk_exp <= drive_sym;
      if (seq_start) begin
        err_r <= 1'b0;
      end else if (chk_valid && ({G1, G0} != chk_exp)) begin
        err_r <= 1'b1;
      end
    end
  end

  assign error = err_r;
`else
  assign error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_req_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_driver
// Purpose  : Directed, table-driven bench for req_driver with a small model
//            of the registered pattern matcher supplying G0/G1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_req_driver;

  localparam int DEPTH = 8;
`ifdef REQ_DRIVER_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic [1:0] sym_in = 2'b00;
  logic       G0 = 1'b0;
  logic       G1 = 1'b0;
  logic       load_ready;
  logic       R1;
  logic       R0;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] g0_count;
  logic [7:0] g1_count;

  req_driver #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .sym_in     (sym_in),
    .load_ready (load_ready),
    .start      (start),
    .R1         (R1),
    .R0         (R0),
    .G0         (G0),
    .G1         (G1),
    .busy       (busy),
    .done       (done),
    .g0_count   (g0_count),
    .g1_count   (g1_count),
    .error      (error)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Observations taken mid-cycle, and matcher model state
  logic [1:0] o_r;
  logic       o_busy;
  logic       o_done;
  logic       o_lr;
  logic       o_err;
  logic       m_ign   = 1'b0;
  logic       corrupt = 1'b0;

  typedef struct packed {
    logic       ld;
    logic [1:0] sym;
    logic       st;
    logic [1:0] exp_r;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_lr;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic ld, input logic [1:0] sym, input logic st,
                              input logic [1:0] r, input logic b, input logic d,
                              input logic lr);
    vec_t v;
    v.ld = ld; v.sym = sym; v.st = st;
    v.exp_r = r; v.exp_busy = b; v.exp_done = d; v.exp_lr = lr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock cycle: apply inputs, observe at negedge, then update the matcher model
  task automatic step(input logic ld, input logic [1:0] s, input logic st);
    logic rst_now;
    load = ld; sym_in = s; start = st;
    @(negedge clock);
    o_r    = {R1, R0};
    o_busy = busy;
    o_done = done;
    o_lr   = load_ready;
    o_err  = error;
    rst_now = reset;
    @(posedge clock);
    #1;
    if (rst_now) begin
      m_ign = 1'b0;
      {G1, G0} = 2'b00;
    end else if (m_ign) begin
      m_ign = 1'b0;
      {G1, G0} = 2'b10;
    end else begin
      if (o_r == 2'b11) begin
        {G1, G0} = 2'b01;
        m_ign = 1'b1;
      end else begin
        {G1, G0} = o_r;
      end
      if (corrupt && (o_r == 2'b01)) G1 = 1'b1;
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(vecs[i].ld, vecs[i].sym, vecs[i].st);
      chk($sformatf("v%0d_r", i),    32'(o_r),    32'(vecs[i].exp_r));
      chk($sformatf("v%0d_busy", i), 32'(o_busy), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_done", i), 32'(o_done), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_lr", i),   32'(o_lr),   32'(vecs[i].exp_lr));
    end
  endtask

  initial begin
    // Sequence 1: 01,10,00 (load during SEND and start during SEND are ignored)
    vecs[0]  = mk(1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    vecs[1]  = mk(1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    vecs[2]  = mk(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    vecs[3]  = mk(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    vecs[4]  = mk(1'b0, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 2'b11, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    vecs[9]  = mk(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    // Sequence 2: 11,01 -> 11, GAP, 01, DRAIN
    vecs[10] = mk(1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    vecs[11] = mk(1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    vecs[12] = mk(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    vecs[13] = mk(1'b0, 2'b00, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
    vecs[14] = mk(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
    vecs[16] = mk(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    vecs[17] = mk(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);

    // Reset state
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    chk("rst_r", 32'(o_r), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_g0", 32'(g0_count), 32'd0);
    chk("rst_g1", 32'(g1_count), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    reset = 1'b0;

    run_rows(0, 9);
    chk("seq1_g0", 32'(g0_count), 32'd1);
    chk("seq1_g1", 32'(g1_count), 32'd1);
    chk("seq1_err", 32'(error), 32'd0);

    run_rows(10, 17);
    chk("seq2_g0", 32'(g0_count), 32'd2);
    chk("seq2_g1", 32'(g1_count), 32'd1);
    chk("seq2_err", 32'(error), 32'd0);

    // Fill FIFO to DEPTH, try an extra load, then play everything back in order
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 2'(i % 3), 1'b0);
      chk($sformatf("fill%0d_lr", i), 32'(o_lr), 32'd1);
    end
    step(1'b1, 2'b11, 1'b0);
    chk("full_lr", 32'(o_lr), 32'd0);
    step(1'b0, 2'b00, 1'b1);
    chk("full_start_lr", 32'(o_lr), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 2'b00, 1'b0);
      chk($sformatf("play%0d_r", i), 32'(o_r), 32'(i % 3));
      chk($sformatf("play%0d_busy", i), 32'(o_busy), 32'd1);
    end
    step(1'b0, 2'b00, 1'b0);
    chk("full_drain_r", 32'(o_r), 32'd0);
    chk("full_drain_busy", 32'(o_busy), 32'd1);
    step(1'b0, 2'b00, 1'b0);
    chk("full_done", 32'(o_done), 32'd1);
    chk("full_g0", 32'(g0_count), 32'd3);
    chk("full_g1", 32'(g1_count), 32'd2);

    // Reset in the middle of SEND, with load/start asserted alongside reset
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b00, 1'b0);
    chk("mid_send1_r", 32'(o_r), 32'b01);
    reset = 1'b1;
    step(1'b0, 2'b00, 1'b0);
    chk("mid_send2_r", 32'(o_r), 32'b10);
    step(1'b1, 2'b01, 1'b1);
    chk("after_rst_r", 32'(o_r), 32'd0);
    chk("after_rst_busy", 32'(o_busy), 32'd0);
    chk("after_rst_lr", 32'(o_lr), 32'd1);
    reset = 1'b0;
    chk("after_rst_g0", 32'(g0_count), 32'd0);
    chk("after_rst_g1", 32'(g1_count), 32'd0);
    // Start with the FIFO empty must be ignored
    step(1'b0, 2'b00, 1'b1);
    chk("empty_start_busy0", 32'(o_busy), 32'd0);
    step(1'b0, 2'b00, 1'b0);
    chk("empty_start_busy1", 32'(o_busy), 32'd0);
    chk("empty_start_done", 32'(o_done), 32'd0);
    chk("empty_start_r", 32'(o_r), 32'd0);

    // Corrupted response after symbol 01: error set and held until next start
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    corrupt = 1'b1;
    step(1'b0, 2'b00, 1'b0);
    chk("bad_send_r", 32'(o_r), 32'b01);
    corrupt = 1'b0;
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    chk("bad_drain_err", 32'(o_err), 32'(EXP_ERR));
    step(1'b0, 2'b00, 1'b0);
    chk("bad_done", 32'(o_done), 32'd1);
    chk("bad_done_err", 32'(o_err), 32'(EXP_ERR));
    step(1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    chk("bad_hold_err", 32'(o_err), 32'(EXP_ERR));
    step(1'b0, 2'b00, 1'b0);
    chk("clear_err", 32'(o_err), 32'd0);
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    chk("clear_done", 32'(o_done), 32'd1);
    chk("clear_err_end", 32'(o_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
